// File: rtl/bitscan_seq_pkg.sv
// Shared constants for the bit-scan scheduler: FSM state encodings and scan direction codes.
package bitscan_seq_pkg;

    localparam int ORDER_DEFAULT = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

endpackage

// File: rtl/bitscan_pick.sv
// Combinational pick of the next set bit from a mask, in LSB-first or MSB-first order.
// One trailing-one finder serves both directions: MSB-first scans the bit-reversed mask.
module bitscan_pick
    import bitscan_seq_pkg::*;
#(
    parameter int ORDER = ORDER_DEFAULT,
    parameter int W     = 2 ** ORDER
) (
    input  logic [W-1:0]     mask,
    input  logic             dir,
    output logic [ORDER-1:0] index,
    output logic [W-1:0]     onehot,
    output logic             last
);

    logic [W-1:0]     scan_vec;
    logic [ORDER-1:0] pos;

    always_comb begin
        scan_vec = '0;
        for (int p = 0; p < W; p++) begin
            scan_vec[p] = (dir == DIR_MSB) ? mask[W-1-p] : mask[p];
        end
    end

    // Walking down from the top leaves the lowest set position in pos.
    always_comb begin
        pos = '0;
        for (int p = W - 1; p >= 0; p--) begin
            if (scan_vec[p]) begin
                pos = p[ORDER-1:0];
            end
        end
    end

    // W is a power of two, so W-1-pos is simply ~pos.
    always_comb begin
        index = '0;
        if (mask != '0) begin
            index = (dir == DIR_MSB) ? ~pos : pos;
        end
    end

    always_comb begin
        onehot = '0;
        if (mask != '0) begin
            onehot[index] = 1'b1;
        end
    end

    assign last = (mask != '0) && ((mask & (mask - W'(1))) == '0);

endmodule

// File: rtl/bitscan_seq.sv
// Sequential bit-scan scheduler: loads one word, then emits one set-bit index per beat.
// Define BITSCAN_SEQ_BYPASS_EN to accept the next word on the last-beat cycle (no bubble).
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// SCAN  | presenting beats, one index per out_valid&&out_ready
module bitscan_seq
    import bitscan_seq_pkg::*;
#(
    parameter int ORDER = ORDER_DEFAULT,
    parameter int W     = 2 ** ORDER
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ORDER-1:0] out_index,
    output logic             out_last,
    output logic             out_zero,
    output logic [ORDER:0]   count,
    output logic             busy
);

    logic [0:0]       state;
    logic [W-1:0]     mask;
    logic             dir;
    logic             zero;

    logic [ORDER-1:0] pick_index;
    logic [W-1:0]     pick_onehot;
    logic             pick_last;
    logic [ORDER:0]   in_popcount;
    logic             load;
    logic             beat;

    bitscan_pick #(
        .ORDER (ORDER),
        .W     (W)
    ) u_pick (
        .mask   (mask),
        .dir    (dir),
        .index  (pick_index),
        .onehot (pick_onehot),
        .last   (pick_last)
    );

    always_comb begin
        in_popcount = '0;
        for (int i = 0; i < W; i++) begin
            in_popcount = in_popcount + {{ORDER{1'b0}}, in_data[i]};
        end
    end

    assign out_valid = (state == ST_SCAN);
    assign busy      = (state == ST_SCAN);
    assign out_index = pick_index;
    assign out_last  = pick_last || zero;
    assign out_zero  = zero;
    assign beat      = out_valid && out_ready;

`ifdef BITSCAN_SEQ_BYPASS_EN
    assign in_ready = (state == ST_IDLE) || (beat && out_last);
`else
    assign in_ready = (state == ST_IDLE);
`endif

    assign load = in_valid && in_ready;

    // A load on the last-beat cycle overrides the beat update, keeping state in SCAN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            mask  <= '0;
            dir   <= DIR_LSB;
            zero  <= 1'b0;
            count <= '0;
        end else if (load) begin
            state <= ST_SCAN;
            mask  <= in_data;
            dir   <= in_dir;
            zero  <= (in_data == '0);
            count <= in_popcount;
        end else if (beat) begin
            mask <= mask & ~pick_onehot;
            if (out_last) begin
                state <= ST_IDLE;
                zero  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/bitscan_seq.md
Name: bitscan_seq

Overview:
- Sequential bit-scan scheduler around the ctz/clz datapath.
- Accepts one W-bit word per valid/ready handshake, then emits the index of every set bit, one per output beat, in the selected direction.
- Sits between a request-mask producer (e.g. pending-IRQ or free-slot vector) and a consumer that services one index at a time.

Parameters:
- ORDER, 3, log2 of word width.
- W, 2**ORDER, word width in bits.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_dir valid.
- in_ready  output  1  block can accept a word.
- in_data  input  W  word to scan.
- in_dir  input  1  0 = LSB first (ctz order), 1 = MSB first (clz order).
- out_valid  output  1  out_index/out_last/out_zero valid.
- out_ready  input  1  consumer accepts the beat.
- out_index  output  ORDER  bit position of current set bit.
- out_last  output  1  final beat of the current word.
- out_zero  output  1  loaded word was all-zero (sole beat).
- count  output  ORDER+1  popcount of last loaded word.
- busy  output  1  scan in progress (state SCAN).

Interface decision: single clock `clock`; `reset` is asynchronous and active-high (always @(posedge reset or posedge clock)).

Behaviour:
- Reset (asynchronous, any time including mid-scan):
  - state=IDLE; mask=0; dir=0; zero flag=0; count=0.
  - Outputs: out_valid=0, in_ready=1, busy=0, out_index=0, out_last=0, out_zero=0.
  - The in-flight word is discarded and no further beats are produced.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SCAN: out_valid=1, in_ready=0 (except with the optional feature).
- Load, on the edge where in_valid&&in_ready:
  - mask<=in_data; dir<=in_dir; count<=popcount(in_data); zero<=(in_data==0); state<=SCAN.
  - First beat is valid the next cycle (latency 1).
- Output path:
  - out_index is combinational from registered mask/dir: ctz(mask) if dir=0, W-1-clz(mask) if dir=1.
  - out_last = (mask has exactly one set bit) || zero.
  - out_zero = zero.
- Beat transfer, on out_valid&&out_ready:
  - mask <= mask with the reported bit cleared.
  - If out_last: state<=IDLE; zero<=0.
- Zero word: exactly one beat with out_index=0, out_zero=1, out_last=1; count=0.
- Backpressure: while out_valid && !out_ready, out_index, out_last and out_zero are held stable. No beat is skipped or duplicated.
- count holds its value until the next load; it is not cleared on return to IDLE.
- Beats per word = max(1, popcount). Indices are strictly increasing (dir=0) or strictly decreasing (dir=1).
- in_data is sampled only at load; later changes are ignored.

Optional Feature:
- Macro: BITSCAN_SEQ_BYPASS_EN.
- Defined: in_ready = IDLE || (out_valid && out_ready && out_last). Load and last-beat transfer in the same cycle: the new word is loaded and state stays SCAN, giving back-to-back words with no bubble.
- Undefined: in_ready=1 only in IDLE, so one idle cycle always separates the last beat of a word from the first beat of the next.

Decomposition:
- Shared header logic/bitscan-defs.vh:
  - state encodings (IDLE=1'b0, SCAN=1'b1);
  - direction constants (DIR_LSB=0, DIR_MSB=1).
- Sub-module bitscan_pick, combinational: (mask, dir) -> index, onehot, last. Built on cix (lead/trail selects) so ctz/clz logic is not duplicated.
- Popcount for count reuses the existing popcount module.

Test Plan:
1. Reset, then in_data=8'h29, dir=0, out_ready=1 -> indices 0,3,5 on three consecutive cycles starting 1 cycle after load; out_last only with 5; count=4'd3; then in_ready=1.
2. in_data=8'h29, dir=1 -> indices 5,3,0; out_last with 0.
3. in_data=8'h00 -> single beat: out_index=0, out_zero=1, out_last=1, count=0; then IDLE.
4. in_data=8'hFF, dir=0, out_ready low for 3 cycles after first out_valid -> out_index held at 0 throughout; then 8 beats 0..7, last on 7, count=4'd8.
5. Load 8'h90, assert reset after the first beat (index 4) -> out_valid=0, busy=0, in_ready=1 immediately; count=0; no beat for index 7.
6. Words 8'h81 then 8'h02 (in_valid held), out_ready=1 -> macro defined: beats 0,7,1 on consecutive cycles; undefined: one-cycle out_valid=0 gap between 7 and 1.
